pe_tensor: RTL and testbench

//   Array of N 3x3 convolution processing elements (PEs) for the DNN accelerator datapath.

---
 rtl/pe_tensor_pkg.sv | 15 +
 rtl/pe_dot9.sv | 58 +++++
 rtl/pe_tensor.sv | 27 ++
 tb/tb_pe_tensor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pe_tensor_pkg.sv
// Shared widths and helpers for the 3x3 convolution PE array.
package pe_tensor_pkg;

    localparam int ELEM_W     = 8;
    localparam int PSUM_W     = 16;
    localparam int TAPS       = 9;
    localparam int LANE_IN_W  = TAPS * ELEM_W;
    localparam int LANE_OUT_W = PSUM_W;

    // Sign-extend one int8 element to psum width.
    function automatic logic [PSUM_W-1:0] sext_elem(input logic [ELEM_W-1:0] x);
        return {{(PSUM_W-ELEM_W){x[ELEM_W-1]}}, x};
    endfunction

endpackage

// File: rtl/pe_dot9.sv
// One lane: weight buffer, nine int8 multipliers (stage 1), adder tree (stage 2).
module pe_dot9
    import pe_tensor_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_write_en,
    input  logic [LANE_IN_W-1:0]  ifmap,
    input  logic [LANE_IN_W-1:0]  filter,
    output logic [LANE_OUT_W-1:0] psum
);

    logic [LANE_IN_W-1:0]         w_q;
    logic [TAPS-1:0][PSUM_W-1:0]  prod_d;
    logic [TAPS-1:0][PSUM_W-1:0]  prod_q;
    logic [PSUM_W-1:0]            sum_d;

    // Weight buffer: loads the whole filter on a write strobe, otherwise holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            w_q <= '0;
        else if (wb_write_en)
            w_q <= filter;
    end

    // Per-tap products; 16-bit modular multiply of sign-extended operands is exact
    // for int8 x int8, so no wider intermediate is needed.
    always_comb begin
        prod_d = '0;
        for (int k = 0; k < TAPS; k++)
            prod_d[k] = sext_elem(ifmap[k*ELEM_W +: ELEM_W]) *
                        sext_elem(w_q[k*ELEM_W +: ELEM_W]);
    end

    // Stage 1: product register (uses weights from before this edge).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            prod_q <= '0;
        else
            prod_q <= prod_d;
    end

    // Adder tree; the sum wraps modulo 2^16 by design, no saturation.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < TAPS; k++)
            sum_d = sum_d + prod_q[k];
    end

    // Stage 2: psum register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            psum <= '0;
        else
            psum <= sum_d;
    end

endmodule

// File: rtl/pe_tensor.sv
// Array of N independent 3x3 dot-product lanes sharing one weight write strobe.
module pe_tensor
    import pe_tensor_pkg::*;
#(
    parameter int N = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_write_en,
    input  logic [N*LANE_IN_W-1:0]  ifmap,
    input  logic [N*LANE_IN_W-1:0]  filter,
    output logic [N*LANE_OUT_W-1:0] psumOut
);

    // One pe_dot9 per lane, each on its own slice of the buses.
    for (genvar g = 0; g < N; g++) begin : g_lane
        pe_dot9 u_pe (
            .clk         (clk),
            .rst         (rst),
            .wb_write_en (wb_write_en),
            .ifmap       (ifmap[g*LANE_IN_W +: LANE_IN_W]),
            .filter      (filter[g*LANE_IN_W +: LANE_IN_W]),
            .psum        (psumOut[g*LANE_OUT_W +: LANE_OUT_W])
        );
    end

endmodule

// File: tb/tb_pe_tensor.sv
// Scoreboard bench for pe_tensor with two lanes: the driver pushes the expected
// psum for every window into a queue, the monitor pops one entry per cycle.
module tb_pe_tensor;

    localparam int N  = 2;
    localparam int IW = 72;
    localparam int OW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wb_write_en = 1'b0;
    logic [N*IW-1:0]   ifmap = '0;
    logic [N*IW-1:0]   filter = '0;
    logic [N*OW-1:0]   psumOut;

    pe_tensor #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_write_en (wb_write_en),
        .ifmap       (ifmap),
        .filter      (filter),
        .psumOut     (psumOut)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    logic [N*OW-1:0] exp_q[$];
    logic [IW-1:0]   model_w[N];

    task automatic check(input string name, input logic [N*OW-1:0] act,
                         input logic [N*OW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: signed int8 dot product in plain integers, low 16 bits kept.
    function automatic logic [OW-1:0] dot9(input logic [IW-1:0] a, input logic [IW-1:0] w);
        int s;
        logic [7:0] ea, ew;
        int prod;
        s = 0;
        for (int k = 0; k < 9; k++) begin
            ea = a[8*k +: 8];
            ew = w[8*k +: 8];
            prod = int'($signed(ea)) * int'($signed(ew));
            s = s + prod;
        end
        return s[OW-1:0];
    endfunction

    function automatic logic [IW-1:0] splat(input logic [7:0] b);
        logic [IW-1:0] v;
        for (int k = 0; k < 9; k++) v[8*k +: 8] = b;
        return v;
    endfunction

    function automatic logic [IW-1:0] rand72();
        return {$urandom_range(255, 0), $urandom(), $urandom()};
    endfunction

    // Put a window on the bus now; expected result uses the weights held before this edge.
    task automatic apply(input logic [N*IW-1:0] a, input logic [N*IW-1:0] f, input logic we);
        logic [N*OW-1:0] e;
        ifmap = a;
        filter = f;
        wb_write_en = we;
        for (int n = 0; n < N; n++)
            e[n*OW +: OW] = dot9(a[n*IW +: IW], model_w[n]);
        exp_q.push_back(e);
        if (we)
            for (int n = 0; n < N; n++) model_w[n] = f[n*IW +: IW];
    endtask

    task automatic drive(input logic [N*IW-1:0] a, input logic [N*IW-1:0] f, input logic we);
        @(negedge clk);
        apply(a, f, we);
    endtask

    // Reset with random inputs toggling: output must clear immediately and stay 0.
    task automatic do_reset(input int cycles);
        mon_en = 1'b0;
        @(negedge clk);
        #2;
        ifmap = {rand72(), rand72()};
        filter = {rand72(), rand72()};
        wb_write_en = 1'b1;
        rst = 1'b0;
        #1;
        check("reset_async", psumOut, '0);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            ifmap = {rand72(), rand72()};
            filter = {rand72(), rand72()};
            wb_write_en = $urandom_range(1, 0);
            check("reset_hold", psumOut, '0);
        end
        // Release on a falling edge; stage 1 still holds zeros, so the first
        // cycle after release shows 0, then the window applied here.
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < N; n++) model_w[n] = '0;
        exp_q.delete();
        exp_q.push_back('0);
        apply({rand72(), rand72()}, '0, 1'b0);
        mon_en = 1'b1;
    endtask

    // Monitor: one psum per cycle, sampled just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got %h expected <none>", psumOut);
                end else begin
                    check("psum", psumOut, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [IW-1:0] diag;
        logic [IW-1:0] win;

        // Power-on reset.
        ifmap = {rand72(), rand72()};
        filter = {rand72(), rand72()};
        #3;
        check("reset_initial", psumOut, '0);
        do_reset(3);

        // After reset weights are zero: any window gives 0.
        for (int i = 0; i < 3; i++)
            drive({rand72(), rand72()}, '0, 1'b0);

        // Identity-diagonal weights on lane 0, random weights on lane 1.
        diag = 72'h010000000100000001;
        drive('0, {rand72(), diag}, 1'b1);
        drive({rand72(), 72'h0FEDCBA987654321}, '0, 1'b0);
        drive({rand72(), 72'h0FADCBA987324321}, '0, 1'b0);
        drive({rand72(), 72'h0FEDCBA987654321}, {rand72(), rand72()}, 1'b0);

        // Overflow wrap in both lanes.
        drive('0, {splat(8'h80), splat(8'h80)}, 1'b1);
        drive({splat(8'h80), splat(8'h80)}, '0, 1'b0);
        drive('0, {splat(8'h7F), splat(8'h7F)}, 1'b1);
        drive({splat(8'h7F), splat(8'h7F)}, '0, 1'b0);
        drive({splat(8'h80), splat(8'h7F)}, '0, 1'b0);

        // Mid-stream reset discards in-flight sums and clears weights.
        drive({rand72(), rand72()}, '0, 1'b0);
        do_reset(2);

        // Weight write on the same edge as a window: that window sees old (zero) weights.
        drive({splat(8'h02), splat(8'h02)}, {splat(8'h01), splat(8'h01)}, 1'b1);
        drive({splat(8'h02), splat(8'h02)}, {rand72(), rand72()}, 1'b0);
        for (int i = 0; i < 6; i++) begin
            win = rand72();
            drive({rand72(), win}, {rand72(), rand72()}, 1'b0);
        end

        // Lane independence: lane0 weights +1, lane1 weights -1.
        drive('0, {splat(8'hFF), splat(8'h01)}, 1'b1);
        drive({splat(8'h03), splat(8'h03)}, '0, 1'b0);
        drive({splat(8'h03), splat(8'h03)}, '0, 1'b0);

        // Random streaming with occasional weight writes.
        for (int i = 0; i < 300; i++)
            drive({rand72(), rand72()}, {rand72(), rand72()}, ($urandom_range(7, 0) == 0));

        // Drain the pipeline.
        for (int i = 0; i < 3; i++)
            drive('0, '0, 1'b0);
        @(posedge clk);
        #2;
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
